mem_ctrl: RTL and testbench

- MEM-stage memory controller: the responder to the execute stage's memory request (mem_rw, mem_addr, mem_write_data, aluop).
- Serialises each load/store into byte accesses on the 8-bit single-port RAM, little-endian.
- Assembles load data with sign or zero extension and stalls the pipeline until the access completes.

---
 rtl/mem_ctrl_pkg.sv | 53 +++++
 rtl/mem_ctrl_ld_ext.sv | 25 ++
 rtl/mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the MEM-stage memory controller: ALU op codes, bus
// widths, FSM state encodings and access-size decode helpers.
package mem_ctrl_pkg;

  localparam int AOP_BUS_W  = 8;
  localparam int RAM_ADDR_W = 17;

  localparam logic [31:0]           ZeroWord    = 32'h0000_0000;
  localparam logic [RAM_ADDR_W-1:0] ZeroRamAddr = '0;

  localparam logic [AOP_BUS_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [AOP_BUS_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [AOP_BUS_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [AOP_BUS_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AOP_BUS_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AOP_BUS_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [AOP_BUS_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [AOP_BUS_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_TAIL   = 2'd2,
    MEM_DONE   = 2'd3
  } mem_state_e;

  // Size codes are chosen to equal (byte count - 1) so they double as the last index.
  typedef enum logic [1:0] {
    MEM_SZ_B = 2'd0,
    MEM_SZ_H = 2'd1,
    MEM_SZ_W = 2'd3
  } mem_size_e;

  function automatic logic isLoad(input logic [AOP_BUS_W-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
           (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic isStore(input logic [AOP_BUS_W-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic mem_size_e opSize(input logic [AOP_BUS_W-1:0] op);
    mem_size_e sz;
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = MEM_SZ_H;
      EXE_LW_OP, EXE_SW_OP:             sz = MEM_SZ_W;
      default:                          sz = MEM_SZ_B;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_ctrl_ld_ext.sv
// Load extender: turns a little-endian assembled 32-bit word and a load op
// into the sign- or zero-extended register result.
module mem_ctrl_ld_ext
  import mem_ctrl_pkg::*;
#(
  parameter int AOP_W = 8
) (
  input  logic [31:0]      i_word,
  input  logic [AOP_W-1:0] i_aluop,
  output logic [31:0]      o_data
);

  always_comb begin
    o_data = ZeroWord;
    case (i_aluop)
      EXE_LB_OP:  o_data = {{24{i_word[7]}}, i_word[7:0]};
      EXE_LBU_OP: o_data = {24'h0, i_word[7:0]};
      EXE_LH_OP:  o_data = {{16{i_word[15]}}, i_word[15:0]};
      EXE_LHU_OP: o_data = {16'h0, i_word[15:0]};
      EXE_LW_OP:  o_data = i_word;
      default:    o_data = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage memory controller: serialises loads/stores into byte accesses on
// an 8-bit RAM. Optional misalignment trap enabled by MEM_MISALIGN_CHK_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int AOP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [AOP_W-1:0]  aluop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              err_o
);

  mem_state_e        r_state;
  logic [AOP_W-1:0]  r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_idx;
  logic [1:0]        r_last;
  logic              r_store;
  logic [31:0]       r_cap;

  logic              r_done;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_ram_a;
  logic [7:0]        r_ram_dout;
  logic              r_ram_wr;
  logic              r_err;

  logic              w_is_ld;
  logic              w_is_st;
  mem_size_e         w_size;
  logic              w_misalign;
  logic [1:0]        w_next;
  logic [1:0]        w_prev;
  logic [31:0]       w_asm;
  logic [31:0]       w_ext;

  assign w_is_ld = isLoad(aluop_i);
  assign w_is_st = isStore(aluop_i);
  assign w_size  = opSize(aluop_i);
  assign w_next  = r_idx + 2'd1;
  assign w_prev  = r_idx - 2'd1;

`ifdef MEM_MISALIGN_CHK_EN
  assign w_misalign = (w_is_ld || w_is_st) &&
                      (((w_size == MEM_SZ_H) && addr_i[0]) ||
                       ((w_size == MEM_SZ_W) && (addr_i[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // The final load byte is still on ram_din_i during TAIL, so merge it in combinationally.
  always_comb begin
    w_asm = r_cap;
    w_asm[8*r_last +: 8] = ram_din_i;
  end

  mem_ctrl_ld_ext #(.AOP_W(AOP_W)) u_ld_ext (
    .i_word  (w_asm),
    .i_aluop (r_op),
    .o_data  (w_ext)
  );

  assign stall_o = ((r_state == MEM_IDLE) && req_i) ||
                   (r_state == MEM_ACCESS) || (r_state == MEM_TAIL);

  // RAM address/data are registered one step ahead so they line up with the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MEM_IDLE;
      r_op       <= '0;
      r_addr     <= '0;
      r_wdata    <= ZeroWord;
      r_idx      <= 2'd0;
      r_last     <= 2'd0;
      r_store    <= 1'b0;
      r_cap      <= ZeroWord;
      r_done     <= 1'b0;
      r_rdata    <= ZeroWord;
      r_ram_a    <= '0;
      r_ram_dout <= 8'h00;
      r_ram_wr   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          r_done   <= 1'b0;
          r_err    <= 1'b0;
          r_ram_wr <= 1'b0;
          if (req_i) begin
            r_op    <= aluop_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_idx   <= 2'd0;
            r_last  <= w_size;
            r_store <= w_is_st;
            if (w_misalign) begin
              r_state <= MEM_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (w_is_ld || w_is_st) begin
              r_state  <= MEM_ACCESS;
              r_ram_a  <= addr_i;
              r_ram_wr <= w_is_st;
              if (w_is_st) begin
                r_ram_dout <= wdata_i[7:0];
              end
            end else begin
              r_state <= MEM_DONE;
              r_done  <= 1'b1;
              r_rdata <= ZeroWord;
            end
          end
        end

        MEM_ACCESS: begin
          if (!r_store && (r_idx != 2'd0)) begin
            r_cap[8*w_prev +: 8] <= ram_din_i;
          end
          if (r_idx == r_last) begin
            r_ram_wr <= 1'b0;
            if (r_store) begin
              r_state <= MEM_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= MEM_TAIL;
            end
          end else begin
            r_idx      <= w_next;
            r_ram_a    <= r_addr + ADDR_W'(w_next);
            r_ram_dout <= r_wdata[8*w_next +: 8];
          end
        end

        MEM_TAIL: begin
          r_ram_wr <= 1'b0;
          r_cap    <= w_asm;
          r_rdata  <= w_ext;
          r_done   <= 1'b1;
          r_state  <= MEM_DONE;
        end

        MEM_DONE: begin
          r_done   <= 1'b0;
          r_err    <= 1'b0;
          r_ram_wr <= 1'b0;
          r_state  <= MEM_IDLE;
        end

        default: begin
          r_state  <= MEM_IDLE;
          r_done   <= 1'b0;
          r_ram_wr <= 1'b0;
        end
      endcase
    end
  end

  assign done_o     = r_done;
  assign rdata_o    = r_rdata;
  assign ram_a_o    = r_ram_a;
  assign ram_dout_o = r_ram_dout;
  assign ram_wr_o   = r_ram_wr;
  assign err_o      = r_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide RAM model that
// returns read data one cycle after the address is presented.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 17;
  localparam int AOP_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic [AOP_W-1:0]  aluop;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              stall;
  logic              done;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] ramA;
  logic [7:0]        ramDout;
  logic              ramWr;
  logic [7:0]        ramDin;
  logic              err;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              preEn;
  logic [ADDR_W-1:0] preAddr;
  logic [7:0]        preData;
  logic [ADDR_W-1:0] wrAddr[$];
  logic [7:0]        wrData[$];
  int                wrCyc[$];
  int                cycle = 0;

  int nChecks = 0;
  int nFails  = 0;

  mem_ctrl #(.ADDR_W(ADDR_W), .AOP_W(AOP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .aluop_i    (aluop),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .stall_o    (stall),
    .done_o     (done),
    .rdata_o    (rdata),
    .ram_a_o    (ramA),
    .ram_dout_o (ramDout),
    .ram_wr_o   (ramWr),
    .ram_din_i  (ramDin),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (preEn) begin
      mem[preAddr] <= preData;
    end else if (ramWr) begin
      mem[ramA] <= ramDout;
      wrAddr.push_back(ramA);
      wrData.push_back(ramDout);
      wrCyc.push_back(cycle);
    end
    ramDin <= mem[ramA];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    preEn = 1'b1; preAddr = a; preData = d;
    @(posedge clk); #1;
    preEn = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyStall);
    lat = 0;
    busyStall = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (stall) busyStall++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [ADDR_W-1:0] a,
                               input logic [31:0] wd, output int lat);
    int busyStall;
    req = 1'b1; aluop = op; addr = a; wdata = wd;
    #1;
    checkOutput("stallAccept", 32'(stall), 32'd1);
    waitDone(lat, busyStall);
    checkOutput("stallBusy", busyStall, lat - 1);
    checkOutput("stallDone", 32'(stall), 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int nWr;
    int busyStall;
    rst_n = 1'b0; req = 1'b0; aluop = '0; addr = '0; wdata = '0;
    preEn = 1'b0; preAddr = '0; preData = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstDone", 32'(done), 0);
    checkOutput("rstRdata", rdata, 0);
    checkOutput("rstRamWr", 32'(ramWr), 0);
    checkOutput("rstRamA", 32'(ramA), 0);
    checkOutput("rstErr", 32'(err), 0);
    checkOutput("rstStall", 32'(stall), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SW of 0x11223344 to 0x100
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
    applyStimulus(EXE_SW_OP, 17'h00100, 32'h11223344, lat);
    checkOutput("swLat", lat, 5);
    checkOutput("swErr", 32'(err), 0);
    checkOutput("swNumWr", wrAddr.size(), 4);
    if (wrAddr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("swAddr%0d", i), 32'(wrAddr[i]), 32'h100 + i);
      end
      checkOutput("swData0", 32'(wrData[0]), 32'h44);
      checkOutput("swData1", 32'(wrData[1]), 32'h33);
      checkOutput("swData2", 32'(wrData[2]), 32'h22);
      checkOutput("swData3", 32'(wrData[3]), 32'h11);
      checkOutput("swConsec", wrCyc[3] - wrCyc[0], 3);
    end

    // Loads from 0x200..0x203 = 80 7F 01 FE
    preload(17'h00200, 8'h80);
    preload(17'h00201, 8'h7F);
    preload(17'h00202, 8'h01);
    preload(17'h00203, 8'hFE);
    applyStimulus(EXE_LW_OP, 17'h00200, 32'h0, lat);
    checkOutput("lwLat", lat, 6);
    checkOutput("lwData", rdata, 32'hFE017F80);
    applyStimulus(EXE_LB_OP, 17'h00200, 32'h0, lat);
    checkOutput("lbLat", lat, 3);
    checkOutput("lbData", rdata, 32'hFFFFFF80);
    applyStimulus(EXE_LBU_OP, 17'h00200, 32'h0, lat);
    checkOutput("lbuData", rdata, 32'h00000080);
    applyStimulus(EXE_LH_OP, 17'h00200, 32'h0, lat);
    checkOutput("lhLat", lat, 4);
    checkOutput("lhData", rdata, 32'h00007F80);
    applyStimulus(EXE_LH_OP, 17'h00202, 32'h0, lat);
    checkOutput("lhNegData", rdata, 32'hFFFFFE01);
    applyStimulus(EXE_LHU_OP, 17'h00202, 32'h0, lat);
    checkOutput("lhuData", rdata, 32'h0000FE01);

    // Wrap-around LHU at the top of the address space
    preload(17'h1FFFF, 8'hCD);
    preload(17'h00000, 8'hAB);
    applyStimulus(EXE_LHU_OP, 17'h1FFFF, 32'h0, lat);
    checkOutput("wrapData", rdata, 32'h0000ABCD);

    // Reset asserted while the third byte of a SW is on the bus
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
    req = 1'b1; aluop = EXE_SW_OP; addr = 17'h00300; wdata = 32'hAABBCCDD;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("midAddr", 32'(ramA), 32'h302);
    checkOutput("midWr", 32'(ramWr), 1);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    checkOutput("rstWrDrop", 32'(ramWr), 0);
    lat = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    checkOutput("rstNoDone", lat, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    checkOutput("rstNoDoneAfter", lat, 0);
    checkOutput("rstIdleStall", 32'(stall), 0);
    checkOutput("rstNumWr", wrAddr.size(), 2);
    checkOutput("rstByte3", 32'(mem[17'h00303]), 32'h00);
    checkOutput("rstByte0", 32'(mem[17'h00300]), 32'hDD);

    // SB followed by LB with req held high through DONE
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
    req = 1'b1; aluop = EXE_SB_OP; addr = 17'h00400; wdata = 32'h000000A5;
    waitDone(lat, busyStall);
    checkOutput("sbLat", lat, 2);
    aluop = EXE_LB_OP;
    nWr = wrAddr.size();
    checkOutput("sbNumWr", nWr, 1);
    @(posedge clk); #1;
    checkOutput("b2bIdleNoDone", 32'(done), 0);
    checkOutput("b2bIdleStall", 32'(stall), 1);
    waitDone(lat, busyStall);
    checkOutput("b2bLbLat", lat, 3);
    checkOutput("b2bLbData", rdata, 32'hFFFFFFA5);
    checkOutput("b2bNoWr", wrAddr.size(), nWr);
    req = 1'b0;
    @(posedge clk); #1;

    // Misaligned SW at 0x102
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
`ifdef MEM_MISALIGN_CHK_EN
    req = 1'b1; aluop = EXE_SW_OP; addr = 17'h00102; wdata = 32'hCAFEBABE;
    waitDone(lat, busyStall);
    checkOutput("misLat", lat, 1);
    checkOutput("misErr", 32'(err), 1);
    req = 1'b0;
    @(posedge clk); #1;
    checkOutput("misErrPulse", 32'(err), 0);
    checkOutput("misNumWr", wrAddr.size(), 0);
`else
    applyStimulus(EXE_SW_OP, 17'h00102, 32'hCAFEBABE, lat);
    checkOutput("misLat", lat, 5);
    checkOutput("misErr", 32'(err), 0);
    checkOutput("misNumWr", wrAddr.size(), 4);
    checkOutput("misByte102", 32'(mem[17'h00102]), 32'hBE);
    checkOutput("misByte105", 32'(mem[17'h00105]), 32'hCA);
`endif
    checkOutput("misRdataHeld", rdata, 32'hFFFFFFA5);

    // Non-memory op completes immediately with zero result
    applyStimulus(8'h00, 17'h00000, 32'h0, lat);
    checkOutput("nopLat", lat, 1);
    checkOutput("nopData", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
